// File: rtl/riscv_core_arb_pkg.sv
// Shared types for the I-cache / D-cache memory-port arbiter.
// Round-robin tie-breaking is enabled by defining RISCV_CORE_ARB_ROUND_ROBIN_EN.
package riscv_core_arb_pkg;

    localparam int NUM_REQ   = 2;
    localparam int REQ_I_IDX = 0;
    localparam int REQ_D_IDX = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // Maps a one-hot winner vector to the requester id it names.
    function automatic req_id_e winner_id(input logic [NUM_REQ-1:0] winner);
        if (winner[REQ_D_IDX]) begin
            return REQ_D;
        end else begin
            return REQ_I;
        end
    endfunction

endpackage

// File: rtl/riscv_core_arb_pick.sv
// Combinational winner selection for the memory-port arbiter.
// RISCV_CORE_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise D has fixed priority.
module riscv_core_arb_pick
    import riscv_core_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_e            rr_ptr,
    output logic [NUM_REQ-1:0] winner
);

`ifdef RISCV_CORE_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        winner = 2'b00;
        if (req == 2'b11) begin
            winner = (rr_ptr == REQ_D) ? 2'b01 : 2'b10;
        end else begin
            winner = req;
        end
    end
`else
    logic rr_ptr_unused_s;
    assign rr_ptr_unused_s = (rr_ptr == REQ_D);

    // Load/store stalls outrank instruction fetch.
    always_comb begin
        winner = 2'b00;
        if (req[REQ_D_IDX]) begin
            winner = 2'b10;
        end else if (req[REQ_I_IDX]) begin
            winner = 2'b01;
        end else begin
            winner = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// Shares the single AXI memory-request port between I-cache and D-cache refills/writebacks.
// Define RISCV_CORE_ARB_ROUND_ROBIN_EN for round-robin ties (default: D over I).
module riscv_core_mem_arbiter
    import riscv_core_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 256
)
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ic_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_ic_addr,
    output logic                      o_ic_mem_done,
    input  logic                      i_dc_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_dc_addr,
    input  logic                      i_dc_we,
    input  logic [AXI_DATA_WIDTH-1:0] i_dc_wdata,
    output logic                      o_dc_mem_done,
    output logic                      o_mem_req,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic                      o_mem_we,
    output logic [AXI_DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                      i_mem_done,
    output logic [1:0]                o_grant,
    output logic                      o_proto_err
);

    arb_state_e          state_r;
    arb_state_e          state_next_s;
    logic                proto_err_r;
    logic [NUM_REQ-1:0]  req_vec_s;
    logic [NUM_REQ-1:0]  pick_s;
    req_id_e             rr_ptr_s;

    assign req_vec_s[REQ_I_IDX] = i_ic_mem_req;
    assign req_vec_s[REQ_D_IDX] = i_dc_mem_req;

    riscv_core_arb_pick u_pick (
        .req    (req_vec_s),
        .rr_ptr (rr_ptr_s),
        .winner (pick_s)
    );

`ifdef RISCV_CORE_ARB_ROUND_ROBIN_EN
    req_id_e rr_ptr_r;

    // Remember the most recently granted requester for tie-breaking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_r <= REQ_I;
        end else if ((state_r == IDLE) && (pick_s != 2'b00)) begin
            rr_ptr_r <= winner_id(pick_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign rr_ptr_s = rr_ptr_r;
`else
    assign rr_ptr_s = REQ_I;
`endif

    // Arbiter state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sticky flag: a completion arrived while no one owned the port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            proto_err_r <= 1'b0;
        end else if ((state_r == IDLE) && i_mem_done) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    // Next state: grants are held until completion and always return through IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_s[REQ_D_IDX]) begin
                    state_next_s = GRANT_D;
                end else if (pick_s[REQ_I_IDX]) begin
                    state_next_s = GRANT_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (i_mem_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output mux: request fields come live from the owner; request drops with done.
    always_comb begin
        o_grant       = 2'b00;
        o_mem_req     = 1'b0;
        o_mem_addr    = '0;
        o_mem_we      = 1'b0;
        o_mem_wdata   = '0;
        o_ic_mem_done = 1'b0;
        o_dc_mem_done = 1'b0;
        case (state_r)
            IDLE: begin
                o_grant = 2'b00;
            end
            GRANT_I: begin
                o_grant       = 2'b01;
                o_mem_req     = ~i_mem_done;
                o_mem_addr    = i_ic_addr;
                o_ic_mem_done = i_mem_done;
            end
            GRANT_D: begin
                o_grant       = 2'b10;
                o_mem_req     = ~i_mem_done;
                o_mem_addr    = i_dc_addr;
                o_mem_we      = i_dc_we;
                o_mem_wdata   = i_dc_wdata;
                o_dc_mem_done = i_mem_done;
            end
            default: begin
                o_grant = 2'b00;
            end
        endcase
    end

    assign o_proto_err = proto_err_r;

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Randomized scoreboard bench for riscv_core_mem_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_riscv_core_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_done;
    logic          dc_req;
    logic [AW-1:0] dc_addr;
    logic          dc_we;
    logic [DW-1:0] dc_wdata;
    logic          dc_done;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [1:0]    grant;
    logic          proto_err;

    always #5 clk = ~clk;

    riscv_core_mem_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ic_mem_req  (ic_req),
        .i_ic_addr     (ic_addr),
        .o_ic_mem_done (ic_done),
        .i_dc_mem_req  (dc_req),
        .i_dc_addr     (dc_addr),
        .i_dc_we       (dc_we),
        .i_dc_wdata    (dc_wdata),
        .o_dc_mem_done (dc_done),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .o_mem_we      (mem_we),
        .o_mem_wdata   (mem_wdata),
        .i_mem_done    (mem_done),
        .o_grant       (grant),
        .o_proto_err   (proto_err)
    );

    typedef struct packed {
        logic [1:0]    owner;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: who owns the port after the latest edge.
    logic [1:0] m_owner = 2'b00;
    logic       m_proto = 1'b0;
    logic       m_last_d = 1'b0;
    logic       started = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Winner for a request pattern seen while the port is free.
    function automatic logic [1:0] model_pick(input logic i_r, input logic d_r, input logic last_d);
        if (i_r && d_r) begin
`ifdef RISCV_CORE_ARB_ROUND_ROBIN_EN
            return last_d ? 2'b01 : 2'b10;
`else
            return 2'b10;
`endif
        end else if (d_r) begin
            return 2'b10;
        end else if (i_r) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Monitor: compares DUT outputs against the model and the scoreboard.
    logic [1:0] mon_prev = 2'b00;
    exp_t       cur_exp;
    logic       cur_valid = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            check("grant", {254'b0, grant}, {254'b0, m_owner});
            check("mem_req", {255'b0, mem_req}, {255'b0, (m_owner != 2'b00) && !mem_done});
            check("ic_done", {255'b0, ic_done}, {255'b0, (m_owner == 2'b01) && mem_done});
            check("dc_done", {255'b0, dc_done}, {255'b0, (m_owner == 2'b10) && mem_done});
            check("proto_err", {255'b0, proto_err}, {255'b0, m_proto});
            if (grant != 2'b00 && mon_prev == 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    cur_valid = 1'b0;
                    $display("FAIL grant_sb: unexpected grant %b with empty scoreboard", grant);
                end else begin
                    cur_exp   = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("grant_owner", {254'b0, grant}, {254'b0, cur_exp.owner});
                end
            end
            if (grant != 2'b00) begin
                if (cur_valid) begin
                    check("mem_addr", {224'b0, mem_addr}, {224'b0, cur_exp.addr});
                    check("mem_we", {255'b0, mem_we}, {255'b0, cur_exp.we});
                    check("mem_wdata", mem_wdata, cur_exp.wdata);
                end
            end else begin
                check("idle_addr", {224'b0, mem_addr}, 256'b0);
                check("idle_we", {255'b0, mem_we}, 256'b0);
                check("idle_wdata", mem_wdata, 256'b0);
            end
            mon_prev = grant;
        end
    end

    // Stimulus: two cache-controller models, an AXI responder and the reference model.
    logic          ic_pend = 1'b0, dc_pend = 1'b0;
    logic          ic_drop = 1'b0, dc_drop = 1'b0;
    int            resp_cnt = 0;
    logic [1:0]    win;
    logic [DW-1:0] pat_a5;
    initial begin
        pat_a5   = {32{8'hA5}};
        rst      = 1'b1;
        ic_req   = 1'b0;
        ic_addr  = '0;
        dc_req   = 1'b0;
        dc_addr  = '0;
        dc_we    = 1'b0;
        dc_wdata = '0;
        mem_done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            // Advance the model across the edge that just happened.
            if (rst) begin
                m_owner  = 2'b00;
                m_proto  = 1'b0;
                m_last_d = 1'b0;
            end else if (m_owner == 2'b00) begin
                if (mem_done) m_proto = 1'b1;
                win = model_pick(ic_req, dc_req, m_last_d);
                if (win != 2'b00) begin
                    m_owner  = win;
                    m_last_d = (win == 2'b10);
                    if (win == 2'b10) exp_q.push_back({2'b10, dc_addr, dc_we, dc_wdata});
                    else              exp_q.push_back({2'b01, ic_addr, 1'b0, 256'b0});
                    resp_cnt = $urandom_range(0, 5);
                    if ($urandom_range(0, 3) == 0) begin
                        if (win == 2'b10) dc_drop = 1'b1;
                        else              ic_drop = 1'b1;
                    end
                end
            end else if (mem_done) begin
                if (m_owner == 2'b01) ic_pend = 1'b0;
                else                  dc_pend = 1'b0;
                m_owner = 2'b00;
            end
            started = 1'b1;
            #1;
            // Drive inputs for the next edge.
            rst = (cyc < 1) || (cyc == 700) || (cyc == 1500) || (cyc == 2300);
            if (rst) begin
                ic_pend = 1'b0;
                dc_pend = 1'b0;
            end else if (cyc < 2900) begin
                if (!ic_pend && $urandom_range(0, 2) == 0) begin
                    ic_pend = 1'b1;
                    ic_drop = 1'b0;
                    ic_addr = $urandom() & 32'hFFFF_FFE0;
                end
                if (!dc_pend && $urandom_range(0, 2) == 0) begin
                    dc_pend = 1'b1;
                    dc_drop = 1'b0;
                    dc_addr = $urandom() & 32'hFFFF_FFE0;
                    dc_we   = $urandom_range(0, 1) == 1;
                    if ($urandom_range(0, 3) == 0) begin
                        dc_wdata = pat_a5;
                    end else begin
                        for (int k = 0; k < 8; k++) dc_wdata[k*32 +: 32] = $urandom();
                    end
                end
            end
            ic_req   = ic_pend && !ic_drop;
            dc_req   = dc_pend && !dc_drop;
            mem_done = 1'b0;
            if (!rst && m_owner != 2'b00) begin
                if (resp_cnt == 0) mem_done = 1'b1;
                else               resp_cnt--;
            end else if (!rst && $urandom_range(0, 99) == 0) begin
                mem_done = 1'b1;
            end
        end
        @(negedge clk);
        check("sb_drain", 256'(exp_q.size()), 256'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
